// File: rtl/game_io_pkg.sv
// Shared address map for the game I/O peripheral.
// All offsets are word addresses relative to the peripheral base.
package game_io_pkg;

    localparam int unsigned ADDR_BTN_LEVEL   = 32'h000;
    localparam int unsigned ADDR_BTN_PRESS   = 32'h001;
    localparam int unsigned ADDR_FRAME_CNT   = 32'h002;
    localparam int unsigned ADDR_FRAME_FLAG  = 32'h003;
    localparam int unsigned ADDR_SPRITE_BASE = 32'h010;

    // X lives at the returned address, Y at the next one.
    function automatic int unsigned sprite_addr(input int unsigned i);
        return ADDR_SPRITE_BASE + 2 * i;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stability counter and stable level.
// rise_pulse_o is high during the cycle whose edge takes the level from 0 to 1.
module btn_debounce #(
    parameter int unsigned DebounceCycles = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic rise_pulse_o
);

    localparam int unsigned CntW = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            // The increment that would reach DebounceCycles toggles instead.
            if (cnt_q == CntLast) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o      = level_q;
    assign rise_pulse_o = level_d & ~level_q;

endmodule

// File: rtl/game_io_mmio.sv
// Memory-mapped game I/O: debounced buttons with sticky press flags, a frame
// counter/flag fed by the VGA end-of-frame pulse, and sprite coordinate registers.
module game_io_mmio
    import game_io_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 2,
    parameter int unsigned NUM_SPR         = 2,
    parameter int unsigned X_W             = 10,
    parameter int unsigned Y_W             = 9,
    parameter int unsigned ADDR_W          = 12,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BTN-1:0]     btn_in,
    input  logic                   screen_end,
    input  logic                   wren,
    input  logic                   rden,
    input  logic [ADDR_W-1:0]      address,
    input  logic [31:0]            data,
    output logic [31:0]            q,
    output logic [NUM_SPR*X_W-1:0] sprite_x,
    output logic [NUM_SPR*Y_W-1:0] sprite_y,
    output logic                   frame_irq
);

    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_rise;
    logic [NUM_BTN-1:0] press_q, press_d;

    logic               se_q;
    logic               frame_rise;
    logic [31:0]        frame_cnt_q, frame_cnt_d;
    logic               frame_flag_q, frame_flag_d;

    logic [X_W-1:0]     spr_x_q [NUM_SPR];
    logic [X_W-1:0]     spr_x_d [NUM_SPR];
    logic [Y_W-1:0]     spr_y_q [NUM_SPR];
    logic [Y_W-1:0]     spr_y_d [NUM_SPR];

    logic [31:0]        rdata;
    logic [31:0]        q_q, q_d;
    logic               rd_press, rd_flag;

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        btn_debounce #(
            .DebounceCycles(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i       (clock),
            .rst_i       (reset),
            .btn_i       (btn_in[b]),
            .level_o     (btn_level[b]),
            .rise_pulse_o(btn_rise[b])
        );
    end

    assign frame_rise = screen_end & ~se_q;
    assign rd_press   = rden && (address == ADDR_W'(ADDR_BTN_PRESS));
    assign rd_flag    = rden && (address == ADDR_W'(ADDR_FRAME_FLAG));

    // Read mux sees pre-write register values, so a simultaneous write is not visible.
    always_comb begin
        rdata = '0;
        if (address == ADDR_W'(ADDR_BTN_LEVEL)) begin
            rdata[NUM_BTN-1:0] = btn_level;
        end else if (address == ADDR_W'(ADDR_BTN_PRESS)) begin
            rdata[NUM_BTN-1:0] = press_q;
        end else if (address == ADDR_W'(ADDR_FRAME_CNT)) begin
            rdata = frame_cnt_q;
        end else if (address == ADDR_W'(ADDR_FRAME_FLAG)) begin
            rdata[0] = frame_flag_q;
        end
        for (int unsigned i = 0; i < NUM_SPR; i++) begin
            if (address == ADDR_W'(sprite_addr(i))) begin
                rdata[X_W-1:0] = spr_x_q[i];
            end
            if (address == ADDR_W'(sprite_addr(i) + 1)) begin
                rdata[Y_W-1:0] = spr_y_q[i];
            end
        end
    end

    always_comb begin
        // A new set beats a read-clear on the same edge.
        press_d      = (rd_press ? '0 : press_q) | btn_rise;
        frame_flag_d = frame_rise | (frame_flag_q & ~rd_flag);
        frame_cnt_d  = frame_rise ? frame_cnt_q + 32'd1 : frame_cnt_q;
        q_d          = rden ? rdata : q_q;
        spr_x_d      = spr_x_q;
        spr_y_d      = spr_y_q;
        if (wren) begin
            for (int unsigned i = 0; i < NUM_SPR; i++) begin
                if (address == ADDR_W'(sprite_addr(i))) begin
                    spr_x_d[i] = data[X_W-1:0];
                end
                if (address == ADDR_W'(sprite_addr(i) + 1)) begin
                    spr_y_d[i] = data[Y_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            press_q      <= '0;
            se_q         <= 1'b0;
            frame_cnt_q  <= '0;
            frame_flag_q <= 1'b0;
            q_q          <= '0;
            spr_x_q      <= '{default: '0};
            spr_y_q      <= '{default: '0};
        end else begin
            press_q      <= press_d;
            se_q         <= screen_end;
            frame_cnt_q  <= frame_cnt_d;
            frame_flag_q <= frame_flag_d;
            q_q          <= q_d;
            spr_x_q      <= spr_x_d;
            spr_y_q      <= spr_y_d;
        end
    end

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
        assign sprite_x[i*X_W +: X_W] = spr_x_q[i];
        assign sprite_y[i*Y_W +: Y_W] = spr_y_q[i];
    end

    assign q         = q_q;
    assign frame_irq = frame_flag_q;

endmodule

// File: tb/tb_game_io_mmio.sv
// Directed bench for game_io_mmio with a read scoreboard; DEBOUNCE_CYCLES = 4.
module tb_game_io_mmio;

    localparam int unsigned NumBtn  = 2;
    localparam int unsigned NumSpr  = 2;
    localparam int unsigned XW      = 10;
    localparam int unsigned YW      = 9;
    localparam int unsigned AddrW   = 12;
    localparam int unsigned Debounce = 4;

    localparam logic [11:0] ALevel = 12'h000;
    localparam logic [11:0] APress = 12'h001;
    localparam logic [11:0] ACnt   = 12'h002;
    localparam logic [11:0] AFlag  = 12'h003;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NumBtn-1:0]     btn_in;
    logic                  screen_end;
    logic                  wren;
    logic                  rden;
    logic [AddrW-1:0]      address;
    logic [31:0]           data;
    logic [31:0]           q;
    logic [NumSpr*XW-1:0]  sprite_x;
    logic [NumSpr*YW-1:0]  sprite_y;
    logic                  frame_irq;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    game_io_mmio #(
        .NUM_BTN        (NumBtn),
        .NUM_SPR        (NumSpr),
        .X_W            (XW),
        .Y_W            (YW),
        .ADDR_W         (AddrW),
        .DEBOUNCE_CYCLES(Debounce)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_in    (btn_in),
        .screen_end(screen_end),
        .wren      (wren),
        .rden      (rden),
        .address   (address),
        .data      (data),
        .q         (q),
        .sprite_x  (sprite_x),
        .sprite_y  (sprite_y),
        .frame_irq (frame_irq)
    );

    always #5 clock = ~clock;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, compare any read issued on it.
    task automatic step(input logic rd, input logic [11:0] addr, input logic wr,
                        input logic [31:0] wd, input logic [31:0] exp, input string tag);
        rden    = rd;
        wren    = wr;
        address = addr;
        data    = wd;
        if (rd) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        @(posedge clock);
        #1;
        rden = 1'b0;
        wren = 1'b0;
        if (rd) check(q, exp_q.pop_front(), tag_q.pop_front());
    endtask

    task automatic bus_rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
        step(1'b1, addr, 1'b0, 32'h0, exp, tag);
    endtask

    task automatic bus_wr(input logic [11:0] addr, input logic [31:0] wd);
        step(1'b0, addr, 1'b1, wd, 32'h0, "");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 12'h0, 1'b0, 32'h0, 32'h0, "");
    endtask

    task automatic frame_pulse(input int len);
        screen_end = 1'b1;
        idle(len);
        screen_end = 1'b0;
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; btn_in = '0; screen_end = 1'b0;
        wren = 1'b0; rden = 1'b0; address = '0; data = '0;

        // 1: reset state and every mapped address reads 0
        idle(2);
        reset = 1'b0;
        check(q, 32'h0, "rst_q");
        check(32'(sprite_x), 32'h0, "rst_sprite_x");
        check(32'(sprite_y), 32'h0, "rst_sprite_y");
        check(32'(frame_irq), 32'h0, "rst_frame_irq");
        bus_rd(ALevel, 32'h0, "rst_level");
        bus_rd(APress, 32'h0, "rst_press");
        bus_rd(ACnt, 32'h0, "rst_cnt");
        bus_rd(AFlag, 32'h0, "rst_flag");
        for (int i = 0; i < 4; i++) bus_rd(12'h010 + 12'(i), 32'h0, "rst_sprite_reg");

        // 2: level appears after 2 + Debounce edges, press flag is sticky
        btn_in = 2'b01;
        for (int k = 1; k <= 10; k++) bus_rd(ALevel, (k >= 7) ? 32'h1 : 32'h0, "level_rise");
        idle(1);
        check(q, 32'h1, "q_hold");
        bus_rd(APress, 32'h1, "press_first");
        bus_rd(APress, 32'h0, "press_cleared");
        btn_in = 2'b11;
        idle(3);
        btn_in = 2'b01;
        idle(8);
        bus_rd(ALevel, 32'h1, "glitch_level");
        bus_rd(APress, 32'h0, "glitch_press");

        // 3: sprite registers truncate, unmapped and RO writes ignored
        bus_wr(12'h012, 32'h3FF);
        check(32'(sprite_x), 32'hFFC00, "spr1_x");
        bus_wr(12'h013, 32'hFFFFF);
        check(32'(sprite_y), 32'h3FE00, "spr1_y_trunc");
        bus_wr(12'h010, 32'h7ABC);
        check(32'(sprite_x), 32'hFFEBC, "spr0_x_trunc");
        step(1'b1, 12'h011, 1'b1, 32'h0AA, 32'h0, "wr_rd_same_edge");
        bus_rd(12'h011, 32'h0AA, "spr0_y_after");
        bus_wr(12'h014, 32'hFFFFFFFF);
        check(32'(sprite_x), 32'hFFEBC, "unmapped_wr_x");
        check(32'(sprite_y), 32'h3FEAA, "unmapped_wr_y");
        bus_rd(12'h014, 32'h0, "unmapped_rd_014");
        bus_rd(12'h015, 32'h0, "unmapped_rd_015");
        bus_wr(ACnt, 32'h55);
        bus_rd(ACnt, 32'h0, "ro_cnt_wr");
        bus_rd(12'h010, 32'h2BC, "spr0_x_rd");
        bus_rd(12'h013, 32'h1FF, "spr1_y_rd");

        // 4: frame counter counts rising edges only, flag clears on read
        frame_pulse(1);
        frame_pulse(5);
        frame_pulse(1);
        check(32'(frame_irq), 32'h1, "irq_set");
        bus_rd(ACnt, 32'h3, "frame_cnt_3");
        bus_rd(AFlag, 32'h1, "flag_read");
        check(32'(frame_irq), 32'h0, "irq_cleared");
        force dut.frame_cnt_q = 32'hFFFFFFFF;
        idle(1);
        release dut.frame_cnt_q;
        bus_rd(ACnt, 32'hFFFFFFFF, "cnt_preload");
        frame_pulse(1);
        bus_rd(ACnt, 32'h0, "cnt_wrap");
        bus_rd(AFlag, 32'h1, "flag_after_wrap");

        // 5: set wins over read-clear on the same edge
        btn_in = 2'b11;
        idle(5);
        bus_rd(APress, 32'h0, "press_same_edge");
        bus_rd(APress, 32'h2, "press_kept");
        bus_rd(APress, 32'h0, "press_clear2");
        screen_end = 1'b1;
        bus_rd(AFlag, 32'h0, "flag_same_edge");
        check(32'(frame_irq), 32'h1, "irq_kept");
        screen_end = 1'b0;
        bus_rd(AFlag, 32'h1, "flag_kept");
        check(32'(frame_irq), 32'h0, "irq_cleared2");

        // 6: reset mid-debounce discards everything
        bus_wr(12'h010, 32'h155);
        bus_rd(12'h010, 32'h155, "pre_reset_rd");
        btn_in = 2'b00;
        idle(3);
        btn_in = 2'b01;
        reset  = 1'b1;
        idle(1);
        reset  = 1'b0;
        check(q, 32'h0, "mid_rst_q");
        check(32'(sprite_x), 32'h0, "mid_rst_sprite_x");
        check(32'(sprite_y), 32'h0, "mid_rst_sprite_y");
        check(32'(frame_irq), 32'h0, "mid_rst_irq");
        for (int k = 1; k <= 8; k++) bus_rd(ALevel, (k >= 7) ? 32'h1 : 32'h0, "level_restart");
        bus_rd(APress, 32'h1, "press_restart");
        bus_rd(ACnt, 32'h0, "cnt_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_io_mmio.md
Name: game_io_mmio

Overview:
- Memory-mapped I/O peripheral on the processor data bus, beside data RAM, selected by the bus decode.
- Generalises the fixed up/down inputs and the two hard-wired position-register taps into a parametrised set of blocks.
- Button blocks: NUM_BTN debounced buttons with sticky press flags.
- Frame block: a frame counter and flag driven by the VGA screen_end pulse.
- Sprite block: NUM_SPR software-written sprite X/Y coordinate registers, driven straight to the VGA controller.

Parameters:
- NUM_BTN, 2, number of button inputs (1..16).
- NUM_SPR, 2, number of sprite coordinate pairs (1..8).
- X_W, 10, width of each sprite X output.
- Y_W, 9, width of each sprite Y output.
- ADDR_W, 12, bus address width.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a level change (10 ms at 100 MHz). Minimum value 1.

Ports:
- clock  in  1  system clock; the only clock in the block.
- reset  in  1  synchronous, active-high reset.
- btn_in  in  NUM_BTN  raw asynchronous button levels; bit 0 = jump/up, bit 1 = down.
- screen_end  in  1  VGA end-of-frame pulse, sampled on clock.
- wren  in  1  bus write strobe.
- rden  in  1  bus read strobe.
- address  in  ADDR_W  word address (peripheral-relative).
- data  in  32  write data.
- q  out  32  read data, registered.
- sprite_x  out  NUM_SPR*X_W  packed sprite X values; sprite i occupies bits [i*X_W +: X_W].
- sprite_y  out  NUM_SPR*Y_W  packed sprite Y values; sprite i occupies bits [i*Y_W +: Y_W].
- frame_irq  out  1  level output, equal to FRAME_FLAG.

Behaviour:
- Reset: all registers cleared on the clock edge where reset=1.
  - q=0, sprite_x=0, sprite_y=0, frame_irq=0.
  - Debounce counters, stable levels, press flags and FRAME_CNT all cleared.
- Address map (word addresses):
  - 0x000 BTN_LEVEL: RO, debounced levels in bits [NUM_BTN-1:0].
  - 0x001 BTN_PRESS: sticky press flags; cleared by the read.
  - 0x002 FRAME_CNT: RO, 32-bit count, wraps 0xFFFFFFFF -> 0.
  - 0x003 FRAME_FLAG: bit 0; cleared by the read.
  - 0x010+2i: SPRITE_X[i], RW.
  - 0x011+2i: SPRITE_Y[i], RW.
- Unmapped addresses and sprite indices >= NUM_SPR: reads return 0, writes are ignored.
- Writes to RO addresses are ignored.
- Unused upper bits read as 0.
- Read timing:
  - rden at edge N -> q valid after edge N+1 (1-cycle latency).
  - q holds its value when rden=0.
- Write timing: data is taken on the edge where wren=1. Sprite registers keep data[X_W-1:0] or data[Y_W-1:0]; upper bits are dropped, with no clamping.
- wren and rden both asserted: the write is performed and the read returns the pre-write value.
- Button path, per bit:
  - 2-flop synchroniser, then counter compare against the stable level.
  - Counter resets to 0 whenever the synchronised input equals the stable level.
  - Otherwise the counter increments. On reaching DEBOUNCE_CYCLES, the stable level toggles and the counter clears.
  - Latency from raw change to BTN_LEVEL change: 2 + DEBOUNCE_CYCLES cycles.
- BTN_PRESS[b] is set on a 0->1 transition of the stable level.
  - A read of 0x001 returns the current flags and clears them on the same edge.
  - A set and a read-clear on the same edge: the set wins, the flag stays 1 and the read returns the old value.
  - Releases do not set flags.
- Frame path:
  - A rising edge of screen_end (registered previous value = 0, current = 1) increments FRAME_CNT and sets FRAME_FLAG.
  - A multi-cycle high pulse counts once.
  - A set and a read-clear of FRAME_FLAG on the same edge: the set wins.
- Mid-operation reset: pending debounces, flags and sprite positions are discarded. No partial state survives.

Decomposition:
- Package game_io_pkg holds:
  - Address offset constants: ADDR_BTN_LEVEL, ADDR_BTN_PRESS, ADDR_FRAME_CNT, ADDR_FRAME_FLAG, ADDR_SPRITE_BASE.
  - Function sprite_addr(i).
- Sub-module btn_debounce (one instance per button via generate). It contains the synchroniser, counter and stable-level register, and outputs level and rise_pulse.

Test Plan (bench sets DEBOUNCE_CYCLES=4):
1. Reset, then read each mapped address -> q=0 one cycle after rden. sprite_x and sprite_y all 0. frame_irq=0.
2. Hold btn_in[0]=1 for 10 cycles -> BTN_LEVEL bit0=1 at cycle 6; BTN_PRESS read=0x1; second read=0x0.
   - Separately, a 3-cycle glitch on btn_in[1] -> BTN_LEVEL and BTN_PRESS are unchanged.
3. Write 0x3FF to 0x012 and 0xFFFFF to 0x013 (NUM_SPR=2) -> sprite_x[19:10]=0x3FF, sprite_y[17:9]=0x1FF.
   - Write to 0x014 -> no change anywhere; read of 0x014 returns 0.
4. Three screen_end pulses, one held 5 cycles -> FRAME_CNT=3 and frame_irq=1.
   - Read 0x003 -> returns 1; frame_irq drops the next cycle.
   - Preload the counter via a force to 0xFFFFFFFF, then one pulse -> FRAME_CNT=0.
5. Button rise and BTN_PRESS read on the same edge -> read returns 0 and the flag reads 1 afterwards.
   - Same check for screen_end and FRAME_FLAG.
6. Assert reset mid-debounce after a sprite write -> all outputs are 0 the next cycle, and the debounce restarts from 0.
